// File: rtl/reg_write_queue.sv
// reg_write_queue: write-request FIFO sitting in front of the register bank.
// Requests (address, data) arrive over a valid/ready handshake, are buffered,
// and drain one per cycle as a one-hot write enable plus a shared data bus.
// HOLD stalls draining without blocking new pushes.
// Optional feature macro RWQ_BYPASS_EN: an in-range request arriving while the
// queue is empty and not held is written straight through in the same cycle.
module reg_write_queue #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [ADDR_W-1:0]          IN_ADDR,
    input  logic [DATA_W-1:0]          IN_DATA,
    input  logic                       HOLD,
    output logic [NUM_REGS-1:0]        WE_ONEHOT,
    output logic [DATA_W-1:0]          WR_DATA,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       ERR_OOR
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  DEPTH_L    = LVL_W'(DEPTH);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              err_oor_q, err_oor_d;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic              in_ready;
    logic              in_range;
    logic              push_fire;
    logic              store;
    logic              pop;
    logic              bypass;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
        onehot = NUM_REGS'(1) << idx;
    endfunction

    assign head_addr = mem_addr_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];

    // Handshake, bypass, issue and next-state computation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and infers a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        err_oor_d = err_oor_q;
        WE_ONEHOT = '0;
        WR_DATA   = '0;

        // Ready depends on registered occupancy only, never on VALID or HOLD.
        in_ready  = (level_q < DEPTH_L);
        in_range  = ({1'b0, IN_ADDR} < NUM_REGS_L);
        push_fire = IN_VALID & in_ready;
`ifdef RWQ_BYPASS_EN
        bypass    = (level_q == '0) & ~HOLD & IN_VALID & in_range;
`else
        bypass    = 1'b0;
`endif
        // Out-of-range requests complete the handshake but are dropped.
        store     = push_fire & in_range & ~bypass;
        pop       = (level_q != '0) & ~HOLD;

        if (bypass) begin
            WE_ONEHOT = onehot(IN_ADDR);
            WR_DATA   = IN_DATA;
        end else begin
            if (pop) begin
                WE_ONEHOT = onehot(head_addr);
            end
            if (level_q != '0) begin
                WR_DATA = head_data;
            end
        end

        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A push is impossible when full, a pop is impossible when empty,
        // so the count never leaves 0..DEPTH.
        level_d = level_q + LVL_W'(store) - LVL_W'(pop);

        if (push_fire & ~in_range) begin
            err_oor_d = 1'b1;
        end
    end

    // Control state: pointers, occupancy and the sticky error flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_oor_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_oor_q <= err_oor_d;
        end
    end

    // Entry storage: written at the tail on every stored push.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array is deliberately not reset; an entry is only
        // ever read while LEVEL marks it valid, and resetting LEVEL invalidates all.
        if (store) begin
            mem_addr_q[wr_ptr_q] <= IN_ADDR;
            mem_data_q[wr_ptr_q] <= IN_DATA;
        end
    end

    assign IN_READY = in_ready;
    assign LEVEL    = level_q;
    assign ERR_OOR  = err_oor_q;

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed testbench for reg_write_queue. A default instance (8 registers) and
// a 6-register instance share clock and reset; a small register-bank model
// captures what the default instance writes.
module tb_reg_write_queue;

    logic        CLK = 1'b0;
    logic        RST_N;

    logic        in_valid, hold;
    logic [2:0]  in_addr;
    logic [15:0] in_data;
    logic        in_ready;
    logic [7:0]  we;
    logic [15:0] wr_data;
    logic [2:0]  level;
    logic        err_oor;

    logic        v6, hold6;
    logic [2:0]  a6;
    logic [15:0] d6;
    logic        in_ready6;
    logic [5:0]  we6;
    logic [15:0] wr_data6;
    logic [2:0]  level6;
    logic        err6;

    logic [15:0] bank [8];

    int checks = 0;
    int errors = 0;

    reg_write_queue dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_ADDR(in_addr), .IN_DATA(in_data),
        .HOLD(hold), .WE_ONEHOT(we), .WR_DATA(wr_data),
        .LEVEL(level), .ERR_OOR(err_oor)
    );

    reg_write_queue #(.NUM_REGS(6)) dut6 (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(v6), .IN_READY(in_ready6),
        .IN_ADDR(a6), .IN_DATA(d6),
        .HOLD(hold6), .WE_ONEHOT(we6), .WR_DATA(wr_data6),
        .LEVEL(level6), .ERR_OOR(err6)
    );

    always #5 CLK = ~CLK;

    // Register bank model: captures the shared data bus on each enabled register.
    initial for (int r = 0; r < 8; r++) bank[r] = 16'h0;
    always @(posedge CLK) begin
        for (int r = 0; r < 8; r++) begin
            if (we[r]) bank[r] <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; hold = 1'b0; in_addr = '0; in_data = '0;
        v6 = 1'b0; hold6 = 1'b0; a6 = '0; d6 = '0;

        // Reset state
        #2;
        check("rst_we", we, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_level", level, 0);
        check("rst_err", err_oor, 0);
        check("rst_err6", err6, 0);
        #10 RST_N = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);
        check("post_rst_level", level, 0);

        // Single request ADDR=3 DATA=BEEF
        in_valid = 1'b1; in_addr = 3'd3; in_data = 16'hBEEF;
        #1;
`ifdef RWQ_BYPASS_EN
        check("t1_byp_we", we, 8'h08);
        check("t1_byp_data", wr_data, 16'hBEEF);
        check("t1_byp_level", level, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_after_we", we, 0);
        check("t1_after_level", level, 0);
`else
        check("t1_no_early_we", we, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_level1", level, 1);
        check("t1_we", we, 8'h08);
        check("t1_data", wr_data, 16'hBEEF);
        tick();
        check("t1_we_gone", we, 0);
        check("t1_level0", level, 0);
        check("t1_data_zero", wr_data, 0);
`endif

        // HOLD fill to full, stalled 5th request, then in-order drain
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 16'(16'h1111 * (i + 1));
            tick();
        end
        in_addr = 3'd4; in_data = 16'h5555;
        #1;
        check("t2_full_level", level, 4);
        check("t2_full_ready", in_ready, 0);
        check("t2_hold_we", we, 0);
        tick();
        check("t2_stalled_level", level, 4);
        hold = 1'b0;
        #1;
        check("t2_w0_we", we, 8'h01);
        check("t2_w0_data", wr_data, 16'h1111);
        check("t2_w0_ready", in_ready, 0);
        tick();
        check("t2_w1_level", level, 3);
        check("t2_w1_we", we, 8'h02);
        check("t2_w1_data", wr_data, 16'h2222);
        check("t2_w1_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t2_w2_level", level, 3);
        check("t2_w2_we", we, 8'h04);
        check("t2_w2_data", wr_data, 16'h3333);
        tick();
        check("t2_w3_level", level, 2);
        check("t2_w3_we", we, 8'h08);
        check("t2_w3_data", wr_data, 16'h4444);
        tick();
        check("t2_w4_level", level, 1);
        check("t2_w4_we", we, 8'h10);
        check("t2_w4_data", wr_data, 16'h5555);
        tick();
        check("t2_empty_level", level, 0);
        check("t2_empty_we", we, 0);

        // Back-to-back streaming with HOLD low
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 16'hA000 + 16'(i);
            #1;
`ifdef RWQ_BYPASS_EN
            check("t3_byp_we", we, 8'(1 << i));
            check("t3_byp_data", wr_data, 16'hA000 + 16'(i));
            check("t3_byp_level", level, 0);
`else
            if (i > 0) begin
                check("t3_level", level, 1);
                check("t3_we", we, 8'(1 << (i - 1)));
                check("t3_data", wr_data, 16'hA000 + 16'(i - 1));
            end
`endif
            tick();
        end
        in_valid = 1'b0;
        #1;
`ifndef RWQ_BYPASS_EN
        check("t3_last_level", level, 1);
        check("t3_last_we", we, 8'h20);
        check("t3_last_data", wr_data, 16'hA005);
        tick();
`endif
        check("t3_done_level", level, 0);
        check("t3_done_we", we, 0);

        // Two writes to register 5: last write wins
        in_valid = 1'b1; in_addr = 3'd5; in_data = 16'hAAAA;
        tick();
        in_data = 16'h5555;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t4_bank5", bank[5], 16'h5555);
        check("t4_level", level, 0);

        // Out-of-range addresses on the 6-register instance
        v6 = 1'b1; a6 = 3'd6; d6 = 16'h1234;
        #1;
        check("t5_ready6", in_ready6, 1);
        check("t5_oor_no_we", we6, 0);
        tick();
        v6 = 1'b0;
        #1;
        check("t5_err_at6", err6, 1);
        check("t5_level_at6", level6, 0);
        v6 = 1'b1; a6 = 3'd7;
        tick();
        v6 = 1'b0;
        #1;
        check("t5_level_at7", level6, 0);
        check("t5_we_at7", we6, 0);
        v6 = 1'b1; a6 = 3'd5; d6 = 16'h0BAD;
        #1;
`ifdef RWQ_BYPASS_EN
        check("t5_byp_we6", we6, 6'h20);
`endif
        tick();
        v6 = 1'b0;
        #1;
`ifndef RWQ_BYPASS_EN
        check("t5_inrange_level", level6, 1);
        check("t5_inrange_we", we6, 6'h20);
        check("t5_inrange_data", wr_data6, 16'h0BAD);
`endif
        check("t5_err_sticky", err6, 1);
        check("t5_main_err_clear", err_oor, 0);
        tick();
        check("t5_err_still", err6, 1);

        // Reset mid-drain with LEVEL=3
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 16'hF0F0 + 16'(i) * 16'h0101;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("t6_level3", level, 3);
        hold = 1'b0;
        #1;
        check("t6_draining_we", we, 8'h01);
        check("t6_draining_data", wr_data, 16'hF0F0);
        #1 RST_N = 1'b0;
        #1;
        check("t6_async_we", we, 0);
        check("t6_async_data", wr_data, 0);
        check("t6_async_level", level, 0);
        check("t6_async_err6", err6, 0);
        tick();
        #3 RST_N = 1'b1;
        tick();
        check("t6_rel_level", level, 0);
        check("t6_rel_ready", in_ready, 1);
        check("t6_rel_we", we, 0);
        tick();
        check("t6_rel_we2", we, 0);
        check("t6_bank0", bank[0], 16'hA000);
        check("t6_bank1", bank[1], 16'hA001);
        check("t6_bank2", bank[2], 16'hA002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
- Write-request queue that sits directly upstream of the 16-bit register bank.
- Accepts (address, data) write requests through a valid/ready handshake and buffers them in a small FIFO.
- Drains one request per cycle onto the bank as a one-hot write-enable plus a shared 16-bit data bus, honouring a HOLD stall from the datapath.
- Decouples the producers of results (ALU/load unit) from register-bank timing.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
NUM_REGS, 8, registers in the bank; width of WE_ONEHOT; NUM_REGS <= 2^ADDR_W
ADDR_W, 3, request address width
DATA_W, 16, data width; matches the register bank

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous, active-low reset
IN_VALID  input  1  write request present
IN_READY  output  1  queue can accept a request this cycle
IN_ADDR  input  ADDR_W  target register index
IN_DATA  input  DATA_W  write data
HOLD  input  1  bank stall; no write may issue while high
WE_ONEHOT  output  NUM_REGS  one-hot write enable, one bit per register WriteEnable
WR_DATA  output  DATA_W  data presented to the D inputs of all registers
LEVEL  output  clog2(DEPTH)+1  current occupancy
ERR_OOR  output  1  sticky flag: an out-of-range address was received

Behaviour:
- Reset: RST_N low asynchronously clears the pointers and LEVEL to 0, ERR_OOR to 0 and all storage valid state.
  - WE_ONEHOT = 0 immediately; WR_DATA = 0; IN_READY = 1 after release.
  - Reset mid-drain discards every queued entry; no partial write issues.
- Push: occurs at a rising edge when IN_VALID & IN_READY. IN_READY = (LEVEL < DEPTH), computed combinationally from registered state only; no dependence on IN_VALID or HOLD.
- Issue: combinational from the FIFO head.
  - WE_ONEHOT = (LEVEL != 0 && !HOLD) ? (1 << head_addr) : 0.
  - WR_DATA = head_data when LEVEL != 0, else 0.
  - Exactly zero or one bit of WE_ONEHOT is high in any cycle.
- Pop: occurs at the same edge at which the bank captures the data, i.e. any edge where WE_ONEHOT != 0.
- Latency: a request pushed at edge k appears on WE_ONEHOT in cycle k→k+1 (if HOLD low and it is at the head), and is written into the register at edge k+1.
- Throughput: one write per cycle sustained.
- Simultaneous push and pop: LEVEL unchanged; legal at any LEVEL from 1 to DEPTH-1. At LEVEL = DEPTH, IN_READY = 0, so no push occurs even if a pop occurs that cycle.
- Ordering: strict FIFO. Two requests to the same register are written in arrival order; the last write wins.
- Pointers: wrap modulo DEPTH. LEVEL saturates logically at DEPTH and never overflows or underflows.
- Out-of-range (IN_ADDR >= NUM_REGS) with IN_VALID & IN_READY:
  - the request is consumed (handshake completes) but not stored;
  - ERR_OOR sets at that edge and stays set until reset.
- HOLD high: queue retains its contents, WE_ONEHOT = 0, pushes still accepted while not full.

Optional Feature:
- Macro RWQ_BYPASS_EN.
- Defined: when LEVEL == 0, HOLD == 0 and IN_VALID with an in-range address, the request bypasses storage.
  - WE_ONEHOT = 1 << IN_ADDR and WR_DATA = IN_DATA in the same cycle.
  - The entry is not enqueued; zero-cycle latency.
  - IN_READY is unchanged (1 when empty).
- Not defined: every request goes through storage; minimum latency is one cycle as above.

Test Plan:
- Reset, then single request ADDR=3, DATA=0xBEEF, HOLD=0 -> next cycle WE_ONEHOT=8'b0000_1000 and WR_DATA=0xBEEF for exactly one cycle; LEVEL returns to 0.
- HOLD=1, push 4 requests (ADDR 0..3, DATA 0x1111..0x4444) -> IN_READY=0 at LEVEL=4 and a 5th request is stalled. Release HOLD -> four consecutive writes in order 0x1111..0x4444, one per cycle; the stalled request is then accepted.
- Back-to-back streaming push every cycle with HOLD=0 -> LEVEL stays at 1 (0 under RWQ_BYPASS_EN); no bubbles and no drops.
- Two writes to ADDR=5 (0xAAAA then 0x5555) -> the bank register ends at 0x5555.
- With NUM_REGS=6, push ADDR=7 -> handshake completes, LEVEL unchanged, ERR_OOR=1 and remains 1 until RST_N low.
- Assert RST_N low with LEVEL=3 mid-drain -> WE_ONEHOT drops to 0 asynchronously; after release LEVEL=0, IN_READY=1, and no stale writes issue.
